// File: rtl/apc_stim_sink.sv
// apc_stim_sink: APC complex-sample capture FIFO replayed on ready/valid; APC_SINK_PWR_EN adds the pwr_acc power accumulator
module apc_stim_sink #(
  parameter int DATA_BITS  = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data_re,
  input  logic [DATA_BITS-1:0] in_data_im,
  input  logic                 in_valid,
  input  logic                 arm,
  input  logic [LEN_BITS-1:0]  capture_len,
  output logic [DATA_BITS-1:0] out_data_re,
  output logic [DATA_BITS-1:0] out_data_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 capturing,
  output logic                 done,
  output logic                 overflow,
  output logic [LEN_BITS-1:0]  sample_cnt,
`ifdef APC_SINK_PWR_EN
  output logic [2*DATA_BITS+LEN_BITS-1:0] pwr_acc,
`endif
  output logic [LEN_BITS-1:0]  drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t r_state, w_next;
  logic [2*DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic [LEN_BITS-1:0] r_len, r_smp, r_drop;
  logic r_ovf, w_full, w_pop, w_push, w_drop, w_last;
  assign w_full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign out_valid = r_cnt != '0;
  assign w_pop = out_valid && out_ready;
  assign w_push = r_state == CAPTURE && in_valid && !arm && (!w_full || w_pop);
  assign w_drop = r_state == CAPTURE && in_valid && !arm && !w_push;
  assign w_last = w_push && (r_smp + LEN_BITS'(1)) == r_len;
  assign {out_data_im, out_data_re} = out_valid ? r_mem[r_rd] : '0;
  assign capturing = r_state == CAPTURE;
  assign done = r_state == DONE;
  assign overflow = r_ovf;
  assign sample_cnt = r_smp;
  assign drop_cnt = r_drop;
  always_comb w_next = arm ? (capture_len == '0 ? DONE : CAPTURE) : (w_last ? DONE : r_state);
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {in_data_im, in_data_re};
  always_ff @(posedge clk)
    if (rst || arm) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      r_smp <= '0;
      r_drop <= '0;
      r_ovf <= 1'b0;
      r_len <= rst ? '0 : capture_len;
    end else begin
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_push) r_smp <= r_smp + LEN_BITS'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_drop) r_ovf <= 1'b1;
      if (w_drop && r_drop != '1) r_drop <= r_drop + LEN_BITS'(1);
    end
`ifdef APC_SINK_PWR_EN
  localparam int PW = 2*DATA_BITS+LEN_BITS;
  logic signed [2*DATA_BITS-1:0] w_re_x, w_im_x, w_re2, w_im2;
  logic [2*DATA_BITS-1:0] r_sq;
  logic r_sq_v;
  logic [PW-1:0] r_acc;
  logic [PW:0] w_sum;
  assign w_re_x = (2*DATA_BITS)'($signed(in_data_re));
  assign w_im_x = (2*DATA_BITS)'($signed(in_data_im));
  assign w_re2 = w_re_x * w_re_x;
  assign w_im2 = w_im_x * w_im_x;
  assign w_sum = {1'b0, r_acc} + (PW+1)'(r_sq);
  assign pwr_acc = r_acc;
  always_ff @(posedge clk)
    if (rst || arm) begin
      r_sq <= '0;
      r_sq_v <= 1'b0;
      r_acc <= '0;
    end else begin
      r_sq <= w_re2 + w_im2;
      r_sq_v <= w_push;
      if (r_sq_v) r_acc <= w_sum[PW] ? '1 : w_sum[PW-1:0];
    end
`endif
endmodule

// File: tb/tb_apc_stim_sink.sv
// tb_apc_stim_sink: directed table and sequence checks for apc_stim_sink
module tb_apc_stim_sink;
  logic clk = 1'b0;
  logic rst, in_valid, arm, out_ready, out_valid, capturing, done, overflow;
  logic [31:0] in_data_re, in_data_im, out_data_re, out_data_im;
  logic [15:0] capture_len, sample_cnt, drop_cnt;
`ifdef APC_SINK_PWR_EN
  logic [79:0] pwr_acc;
`endif
  int passed = 0;
  int total = 0;
  logic [63:0] got [$];
  typedef struct {
    logic a;
    logic [15:0] len;
    logic v;
    logic [31:0] re;
    logic [31:0] im;
    logic rdy;
    logic ev;
    logic [31:0] ere;
    logic [31:0] eim;
    logic ecap;
    logic edone;
    logic [15:0] esmp;
  } vec_t;
  vec_t tbl [10];
  apc_stim_sink dut (
    .clk(clk), .rst(rst),
    .in_data_re(in_data_re), .in_data_im(in_data_im), .in_valid(in_valid),
    .arm(arm), .capture_len(capture_len),
    .out_data_re(out_data_re), .out_data_im(out_data_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .capturing(capturing), .done(done), .overflow(overflow),
    .sample_cnt(sample_cnt),
`ifdef APC_SINK_PWR_EN
    .pwr_acc(pwr_acc),
`endif
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask
  task automatic cyc(input logic a, input logic [15:0] len, input logic v,
                     input logic [31:0] re, input logic [31:0] im, input logic rdy);
    arm = a;
    capture_len = len;
    in_valid = v;
    in_data_re = re;
    in_data_im = im;
    out_ready = rdy;
    if (out_valid && rdy) got.push_back({out_data_im, out_data_re});
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask
  initial begin
    int errs;
    logic [31:0] e;
    rst = 1'b1;
    arm = 0; capture_len = 0; in_valid = 0; in_data_re = 0; in_data_im = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_re", out_data_re, 0);
    chk("rst_cap", capturing, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_smp", sample_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tbl[0] = '{1'b1, 16'd8, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 16'd0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 16'd8, 1'b1, 32'(i), 32'(-i), 1'b1, 1'b1, 32'(i), 32'(-i), i < 8, i == 8, 16'(i)};
    tbl[9] = '{1'b0, 16'd8, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 16'd8};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].a, tbl[i].len, tbl[i].v, tbl[i].re, tbl[i].im, tbl[i].rdy);
      chk($sformatf("basic%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("basic%0d_re", i), out_data_re, tbl[i].ere);
      chk($sformatf("basic%0d_im", i), out_data_im, tbl[i].eim);
      chk($sformatf("basic%0d_cap", i), capturing, tbl[i].ecap);
      chk($sformatf("basic%0d_done", i), done, tbl[i].edone);
      chk($sformatf("basic%0d_smp", i), sample_cnt, tbl[i].esmp);
    end
    chk("basic_ovf", overflow, 0);
    chk("basic_popped", got.size(), 8);
    rst_pulse();
    got.delete();
    cyc(1, 100, 0, 0, 0, 0);
    for (int k = 0; k < 70; k++) cyc(0, 100, 1, k, k + 1000, 0);
    chk("ovf_smp", sample_cnt, 64);
    chk("ovf_drop", drop_cnt, 6);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cap", capturing, 1);
    for (int k = 70; k < 106; k++) cyc(0, 100, 1, k, k + 1000, 1);
    chk("ovf_smp_end", sample_cnt, 100);
    chk("ovf_done", done, 1);
    chk("ovf_drop_end", drop_cnt, 6);
    for (int k = 0; k < 70; k++) cyc(0, 100, 0, 0, 0, 1);
    chk("ovf_read_cnt", got.size(), 100);
    errs = 0;
    for (int j = 0; j < got.size() && j < 100; j++) begin
      e = (j < 64) ? 32'(j) : 32'(j + 6);
      if (got[j] !== {e + 32'd1000, e}) errs++;
    end
    chk("ovf_read_order", errs, 0);
    rst_pulse();
    got.delete();
    cyc(1, 200, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) cyc(0, 200, 1, k, 0, 0);
    chk("full_smp", sample_cnt, 64);
    chk("full_drop", drop_cnt, 0);
    for (int k = 0; k < 10; k++) cyc(0, 200, 1, 100 + k, 0, 1);
    chk("pp_drop", drop_cnt, 0);
    chk("pp_ovf", overflow, 0);
    chk("pp_smp", sample_cnt, 74);
    for (int k = 0; k < 70; k++) cyc(0, 200, 0, 0, 0, 1);
    chk("pp_total_read", got.size(), 74);
    chk("pp_first", got.size() > 0 ? got[0][31:0] : 32'hdead, 0);
    chk("pp_last", got.size() > 73 ? got[73][31:0] : 32'hdead, 109);
    rst_pulse();
    got.delete();
    cyc(1, 20, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 20, 1, k, 0, 0);
    chk("rearm_pre_smp", sample_cnt, 5);
    cyc(1, 3, 1, 99, 0, 0);
    chk("rearm_empty", out_valid, 0);
    chk("rearm_smp0", sample_cnt, 0);
    chk("rearm_cap", capturing, 1);
    for (int k = 10; k <= 12; k++) cyc(0, 3, 1, k, 0, 0);
    chk("rearm_done", done, 1);
    chk("rearm_smp", sample_cnt, 3);
    cyc(0, 3, 1, 13, 0, 0);
    chk("done_ignores_in", sample_cnt, 3);
    cyc(0, 3, 0, 0, 0, 1);
    cyc(0, 3, 0, 0, 0, 1);
    chk("rearm_read_cnt", got.size(), 2);
    chk("rearm_r0", got.size() > 0 ? got[0][31:0] : 32'hdead, 10);
    chk("rearm_r1", got.size() > 1 ? got[1][31:0] : 32'hdead, 11);
    chk("rearm_head", out_data_re, 12);
    rst_pulse();
    chk("middrain_valid", out_valid, 0);
    chk("middrain_re", out_data_re, 0);
    chk("middrain_done", done, 0);
    chk("middrain_cap", capturing, 0);
    chk("middrain_smp", sample_cnt, 0);
    cyc(1, 0, 1, 5, 5, 0);
    chk("len0_done", done, 1);
    chk("len0_cap", capturing, 0);
    chk("len0_smp", sample_cnt, 0);
    cyc(0, 0, 1, 5, 5, 0);
    chk("len0_no_capture", out_valid, 0);
`ifdef APC_SINK_PWR_EN
    rst_pulse();
    cyc(1, 4, 0, 0, 0, 0);
    cyc(0, 4, 1, 3, 4, 0);
    chk("pwr_lat", pwr_acc, 0);
    cyc(0, 4, 1, -5, 12, 0);
    chk("pwr_25", pwr_acc, 25);
    cyc(0, 4, 0, 0, 0, 0);
    chk("pwr_194", pwr_acc, 194);
    cyc(1, 4, 0, 0, 0, 0);
    chk("pwr_arm_clr", pwr_acc, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
